// File: rtl/mips_single_cycle_datapath.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mips_single_cycle_datapath                                               |
// | Single-cycle MIPS-subset CPU: PC, imem, 32x32 regfile, ALU, dmem.        |
// | Optional multiply/divide enabled by defining MULDIV_EN.                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

module mips_regfile (
    input  logic        clk,
    input  logic        Reset,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);
    logic [31:0] RF [0:31] = '{default: '0};

    assign rd1 = (ra1 == 5'd0) ? '0 : RF[ra1];
    assign rd2 = (ra2 == 5'd0) ? '0 : RF[ra2];

    always_ff @(posedge clk) begin
        if (Reset) begin
            for (int i = 1; i < 32; i++) begin
                RF[i] <= '0;
            end
        end else if (we && (wa != 5'd0)) begin
            RF[wa] <= wd;
        end
    end
endmodule

module mips_imem #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic [AW-1:0] addr,
    output logic [31:0]   rdata
);
    logic [31:0] ram [0:DEPTH-1] = '{default: '0};

    assign rdata = ram[addr];
endmodule

module mips_dmem #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] ram [0:DEPTH-1] = '{default: '0};

    assign rdata = ram[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            ram[addr] <= wdata;
        end
    end
endmodule

module mips_single_cycle_datapath #(
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256
) (
    input  logic clk,
    input  logic Reset
);
    // Depths are assumed to be powers of two so modulo indexing is a bit slice.
    localparam int IAW = $clog2(IMEM_DEPTH);
    localparam int DAW = $clog2(DMEM_DEPTH);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;
`ifdef MULDIV_EN
    localparam logic [5:0] FN_MUL = 6'h18;
    localparam logic [5:0] FN_DIV = 6'h1A;
`endif

    logic [31:0] pc = '0;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic [31:0] instr;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] ea;
    logic [31:0] mem_rdata;
    logic [31:0] reg_wd;
    logic [4:0]  reg_wa;
    logic        reg_we;
    logic        mem_we;
    logic        unused_ea_hi;

    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;

    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign shamt  = instr[10:6];
    assign funct  = instr[5:0];
    assign imm    = instr[15:0];

    mips_imem #(.DEPTH(IMEM_DEPTH), .AW(IAW)) instMem (
        .addr  (pc[IAW+1:2]),
        .rdata (instr)
    );

    mips_regfile rf (
        .clk   (clk),
        .Reset (Reset),
        .ra1   (rs),
        .ra2   (rt),
        .rd1   (rs_val),
        .rd2   (rt_val),
        .we    (reg_we && !Reset),
        .wa    (reg_wa),
        .wd    (reg_wd)
    );

    assign ea           = rs_val + {{16{imm[15]}}, imm};
    assign unused_ea_hi = ^ea[31:DAW];

    mips_dmem #(.DEPTH(DMEM_DEPTH), .AW(DAW)) dataMem (
        .clk   (clk),
        .we    (mem_we && !Reset),
        .addr  (ea[DAW-1:0]),
        .wdata (rt_val),
        .rdata (mem_rdata)
    );

    assign pc_plus4 = pc + 32'd4;

`ifdef MULDIV_EN
    logic [31:0] mul_res;
    logic [31:0] div_res;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] quot;

    // Divide on magnitudes so the most-negative / -1 case simply wraps.
    assign mul_res = rs_val * rt_val;
    assign abs_a   = rs_val[31] ? -rs_val : rs_val;
    assign abs_b   = rt_val[31] ? -rt_val : rt_val;
    assign quot    = abs_a / abs_b;
    assign div_res = (rt_val == '0) ? '1 :
                     ((rs_val[31] ^ rt_val[31]) ? -quot : quot);
`endif

    always_comb begin
        reg_we  = 1'b0;
        reg_wa  = rd;
        reg_wd  = '0;
        mem_we  = 1'b0;
        next_pc = pc_plus4;
        case (opcode)
            OP_RTYPE: begin
                reg_we = 1'b1;
                case (funct)
                    FN_ADD: reg_wd = rs_val + rt_val;
                    FN_SUB: reg_wd = rs_val - rt_val;
                    FN_AND: reg_wd = rs_val & rt_val;
                    FN_OR:  reg_wd = rs_val | rt_val;
                    FN_XOR: reg_wd = rs_val ^ rt_val;
                    FN_NOR: reg_wd = ~(rs_val | rt_val);
                    FN_SLT: reg_wd = {31'b0, $signed(rs_val) < $signed(rt_val)};
                    FN_SLL: reg_wd = rt_val << shamt;
                    FN_SRL: reg_wd = rt_val >> shamt;
                    FN_SRA: reg_wd = $signed(rt_val) >>> shamt;
`ifdef MULDIV_EN
                    FN_MUL: reg_wd = mul_res;
                    FN_DIV: reg_wd = div_res;
`endif
                    default: reg_we = 1'b0;
                endcase
            end
            OP_BEQ: begin
                if (rs_val == rt_val) begin
                    next_pc = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
                end
            end
            OP_BNE: begin
                if (rs_val != rt_val) begin
                    next_pc = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
                end
            end
            OP_LW: begin
                reg_we = 1'b1;
                reg_wa = rt;
                reg_wd = mem_rdata;
            end
            OP_SW: begin
                mem_we = 1'b1;
            end
            OP_J: begin
                next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
            end
            default: begin
                reg_we = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            pc <= '0;
        end else begin
            pc <= next_pc;
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_mips_single_cycle_datapath.sv
`default_nettype none
// Self-checking bench: directed program from the test plan, then random
// programs compared cycle by cycle against an instruction-level model.

module tb_mips_single_cycle_datapath;
    localparam int IMEM_DEPTH = 256;
    localparam int DMEM_DEPTH = 256;

    logic clk   = 1'b0;
    logic Reset = 1'b1;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] prog   [IMEM_DEPTH];
    logic [31:0] m_rf   [32];
    logic [31:0] m_dmem [DMEM_DEPTH];
    logic [31:0] m_pc;
    logic [31:0] rf16;

    mips_single_cycle_datapath #(
        .IMEM_DEPTH (IMEM_DEPTH),
        .DMEM_DEPTH (DMEM_DEPTH)
    ) dut (
        .clk   (clk),
        .Reset (Reset)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                          input int sh, input int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] itype(input int op, input int rs, input int rt,
                                          input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] jtype(input int tgt);
        return {6'h02, 26'(tgt)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [4:0] r, input logic [31:0] v);
        if (r != 5'd0) m_rf[r] = v;
    endtask

    // Instruction-level reference: executes one instruction on the model state.
    task automatic model_step(input bit rst);
        logic [31:0] ins, a, b, npc, off, addr;
        logic [4:0]  rs, rt, rd, sh;
        int          sa, sb;
        if (rst) begin
            m_pc = 0;
            for (int i = 1; i < 32; i++) m_rf[i] = 0;
            return;
        end
        ins  = prog[(m_pc >> 2) % IMEM_DEPTH];
        rs   = ins[25:21];
        rt   = ins[20:16];
        rd   = ins[15:11];
        sh   = ins[10:6];
        a    = m_rf[rs];
        b    = m_rf[rt];
        sa   = a;
        sb   = b;
        off  = {{16{ins[15]}}, ins[15:0]};
        addr = (a + off) % DMEM_DEPTH;
        npc  = m_pc + 4;
        case (ins[31:26])
            6'h00: begin
                case (ins[5:0])
                    6'h20: wr(rd, a + b);
                    6'h22: wr(rd, a - b);
                    6'h24: wr(rd, a & b);
                    6'h25: wr(rd, a | b);
                    6'h26: wr(rd, a ^ b);
                    6'h27: wr(rd, ~(a | b));
                    6'h2A: wr(rd, (sa < sb) ? 32'd1 : 32'd0);
                    6'h00: wr(rd, b << sh);
                    6'h02: wr(rd, b >> sh);
                    6'h03: wr(rd, 32'(sb >>> sh));
`ifdef MULDIV_EN
                    6'h18: wr(rd, 32'(sa * sb));
                    6'h1A: begin
                        if (sb == 0) wr(rd, 32'hFFFF_FFFF);
                        else if (a == 32'h8000_0000 && sb == -1) wr(rd, 32'h8000_0000);
                        else wr(rd, 32'(sa / sb));
                    end
`endif
                    default: ;
                endcase
            end
            6'h04: if (a == b) npc = m_pc + 4 + (off << 2);
            6'h05: if (a != b) npc = m_pc + 4 + (off << 2);
            6'h23: wr(rt, m_dmem[addr]);
            6'h2B: m_dmem[addr] = b;
            6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
            default: ;
        endcase
        m_pc = npc;
    endtask

    task automatic step(input bit rst);
        Reset = rst;
        model_step(rst);
        @(posedge clk);
        #1;
        chk("pc", dut.pc, m_pc);
    endtask

    task automatic check_rf(input string tag);
        for (int i = 0; i < 32; i++)
            chk($sformatf("%s rf[%0d]", tag, i), dut.rf.RF[i], m_rf[i]);
    endtask

    task automatic set_reg(input int r, input logic [31:0] v);
        dut.rf.RF[r] = v;
        m_rf[r]      = v;
    endtask

    task automatic load_prog();
        for (int i = 0; i < IMEM_DEPTH; i++) dut.instMem.ram[i] = prog[i];
    endtask

    function automatic logic [31:0] rand_instr();
        int k  = $urandom_range(0, 19);
        int rs = $urandom_range(0, 7);
        int rt = $urandom_range(0, 7);
        int rd = $urandom_range(0, 7);
        int sh = $urandom_range(0, 31);
        case (k)
            0:  return rtype(rs, rt, rd, 0, 'h20);
            1:  return rtype(rs, rt, rd, 0, 'h22);
            2:  return rtype(rs, rt, rd, 0, 'h24);
            3:  return rtype(rs, rt, rd, 0, 'h25);
            4:  return rtype(rs, rt, rd, 0, 'h26);
            5:  return rtype(rs, rt, rd, 0, 'h27);
            6:  return rtype(rs, rt, rd, 0, 'h2A);
            7:  return rtype(0, rt, rd, sh, 'h00);
            8:  return rtype(0, rt, rd, sh, 'h02);
            9:  return rtype(0, rt, rd, sh, 'h03);
            10: return rtype(rs, rt, rd, 0, 'h18);
            11: return rtype(rs, rt, rd, 0, 'h1A);
            12: return rtype(rs, rt, rd, 0, 'h01);
            13: return itype('h04, rs, rt, $urandom_range(0, 4));
            14: return itype('h05, rs, rt, $urandom_range(0, 4));
            15: return itype('h23, rs, rt, $urandom_range(0, 65535));
            16: return itype('h2B, rs, rt, $urandom_range(0, 65535));
            17: return jtype($urandom_range(0, 255));
            18: return itype('h3F, rs, rt, $urandom_range(0, 65535));
            default: return itype('h23, rs, rt, $urandom_range(0, 300));
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) m_rf[i] = 0;
        for (int i = 0; i < DMEM_DEPTH; i++) m_dmem[i] = 0;
        for (int i = 0; i < IMEM_DEPTH; i++) prog[i] = 32'h0;
        prog[0]  = rtype(0, 0, 9, 0, 'h20);
        prog[1]  = jtype(3);
        prog[2]  = rtype(10, 10, 10, 0, 'h20);
        prog[3]  = rtype(9, 10, 11, 0, 'h22);
        prog[4]  = rtype(0, 8, 13, 2, 'h00);
        prog[5]  = rtype(10, 8, 14, 0, 'h2A);
        prog[6]  = itype('h04, 14, 10, 2);
        prog[7]  = itype('h05, 14, 10, 2);
        prog[8]  = rtype(13, 13, 13, 0, 'h20);
        prog[9]  = rtype(13, 13, 13, 0, 'h20);
        prog[10] = rtype(12, 15, 18, 0, 'h24);
        prog[11] = rtype(12, 15, 19, 0, 'h25);
        prog[12] = rtype(12, 15, 20, 0, 'h26);
        prog[13] = rtype(12, 15, 23, 0, 'h27);
        prog[14] = itype('h2B, 8, 16, 3);
        prog[15] = 32'h0;
        prog[16] = itype('h23, 8, 17, 3);
        prog[17] = rtype(10, 8, 21, 0, 'h18);
        prog[18] = rtype(13, 11, 22, 0, 'h1A);
        prog[19] = rtype(13, 0, 25, 0, 'h1A);
        prog[20] = rtype(0, 24, 26, 2, 'h03);
        prog[21] = rtype(0, 24, 27, 2, 'h02);
        prog[22] = jtype(22);
        load_prog();
        m_pc  = 0;
        Reset = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_pc", dut.pc, 32'h0);
        chk("reset_rf9", dut.rf.RF[9], 32'h0);

        Reset = 1'b0;
        rf16  = $urandom();
        set_reg(8, 32'd123);
        set_reg(10, 32'hFFFF_FFF6);
        set_reg(12, 32'h0E80_4820);
        set_reg(15, 32'h8080_4883);
        set_reg(16, rf16);
        set_reg(21, 32'h5A5A_0021);
        set_reg(22, 32'h5A5A_0022);
        set_reg(25, 32'h5A5A_0025);
        set_reg(24, 32'h8000_0005);
        for (int c = 0; c < 23; c++) step(1'b0);

        chk("add_zero", dut.rf.RF[9], 32'h0);
        chk("jump_skip", dut.rf.RF[10], 32'hFFFF_FFF6);
        chk("sub", dut.rf.RF[11], 32'd10);
        chk("sll", dut.rf.RF[13], 32'd492);
        chk("slt", dut.rf.RF[14], 32'd1);
        chk("and", dut.rf.RF[18], 32'h0080_4800);
        chk("or", dut.rf.RF[19], 32'h8E80_48A3);
        chk("xor", dut.rf.RF[20], 32'h8E00_00A3);
        chk("nor", dut.rf.RF[23], 32'h717F_B75C);
        chk("sw_lw", dut.rf.RF[17], rf16);
        chk("dmem126", dut.dataMem.ram[126], rf16);
`ifdef MULDIV_EN
        chk("mul", dut.rf.RF[21], 32'hFFFF_FB32);
        chk("div", dut.rf.RF[22], 32'd49);
        chk("div0", dut.rf.RF[25], 32'hFFFF_FFFF);
`else
        chk("mul_off", dut.rf.RF[21], 32'h5A5A_0021);
        chk("div_off", dut.rf.RF[22], 32'h5A5A_0022);
        chk("div0_off", dut.rf.RF[25], 32'h5A5A_0025);
`endif
        chk("sra", dut.rf.RF[26], 32'hE000_0001);
        chk("srl", dut.rf.RF[27], 32'h2000_0001);
        chk("loop_pc", dut.pc, 32'd88);
        check_rf("directed");

        // Reset lands on a jump: reset must win.
        step(1'b1);
        chk("reset_mid_pc", dut.pc, 32'h0);
        chk("reset_mid_rf11", dut.rf.RF[11], 32'h0);
        chk("dmem_kept", dut.dataMem.ram[126], rf16);
        check_rf("after_reset");
        step(1'b0);
        chk("restart_pc", dut.pc, 32'd4);

        for (int i = 0; i < IMEM_DEPTH; i++) prog[i] = rand_instr();
        load_prog();
        for (int i = 1; i < 32; i++) set_reg(i, $urandom());
        for (int i = 0; i < DMEM_DEPTH; i++) begin
            m_dmem[i]             = $urandom();
            dut.dataMem.ram[i]    = m_dmem[i];
        end
        for (int c = 0; c < 800; c++) begin
            step($urandom_range(0, 63) == 0);
            if (c % 16 == 15) check_rf("random");
        end
        check_rf("random_end");
        for (int i = 0; i < DMEM_DEPTH; i++)
            chk($sformatf("dmem[%0d]", i), dut.dataMem.ram[i], m_dmem[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
